// File: rtl/scc_pkg.sv
// Shared constants for the single-issue core: datapath width, register-select
// width, CPSR bit positions and the writeback data-mux encoding.
package scc_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_SEL_W = 3;

   // CPSR bit order is N,C,Z,V from MSB to LSB
   localparam int FLAG_N = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

   localparam logic W_SEL_ALU = 1'b0;
   localparam logic W_SEL_ID  = 1'b1;

endpackage

// File: rtl/reg_array.sv
// General register storage: one synchronous write port, two asynchronous read
// ports, synchronous active-low clear of every entry.
module reg_array #(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 32,
   parameter int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [SEL_W-1:0]  w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [SEL_W-1:0]  r_addr_0,
   output logic [DATA_W-1:0] r_data_0,
   input  logic [SEL_W-1:0]  r_addr_1,
   output logic [DATA_W-1:0] r_data_1
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   // NOTE: this array is cleared on reset because software relies on every
   // register reading zero after reset; that forces flops rather than RAM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[w_addr] <= w_data;
      end
   end

   assign r_data_0 = mem[r_addr_0];
   assign r_data_1 = mem[r_addr_1];

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage register with read bypass in front of the general register
// array, plus the CPSR flag register.
module reg_writeback
   import scc_pkg::*;
#(
   parameter int NUM_REGS = 2 ** REG_SEL_W,
   parameter int DATA_W   = scc_pkg::DATA_W,
   parameter int FLAG_W   = 4,
   parameter int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SEL_W-1:0]  r_sel_0,
   input  logic [SEL_W-1:0]  r_sel_1,
   output logic [DATA_W-1:0] r_val_0,
   output logic [DATA_W-1:0] r_val_1,
   input  logic [SEL_W-1:0]  dest_reg,
   input  logic              w_enable,
   input  logic              w_select,
   input  logic [DATA_W-1:0] w_alu,
   input  logic [DATA_W-1:0] w_id,
   input  logic              flags_we,
   input  logic [FLAG_W-1:0] flags_in,
   output logic [FLAG_W-1:0] flags,
   input  logic              stall,
   output logic              wb_valid,
   output logic [SEL_W-1:0]  wb_dest
);

   logic [DATA_W-1:0] wb_data;
   logic [SEL_W-1:0]  sel_0;
   logic [SEL_W-1:0]  sel_1;
   logic [DATA_W-1:0] arr_val_0;
   logic [DATA_W-1:0] arr_val_1;
   logic              commit;

   // Selects wrap modulo NUM_REGS so non-power-of-two sizes never index out of range
   function automatic logic [SEL_W-1:0] wrap_sel(input logic [SEL_W-1:0] sel);
      return SEL_W'(int'(sel) % NUM_REGS);
   endfunction

   assign sel_0  = wrap_sel(r_sel_0);
   assign sel_1  = wrap_sel(r_sel_1);
   assign commit = wb_valid && !stall;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; this is what lets commit and capture share one edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
         wb_dest  <= '0;
         wb_data  <= '0;
         flags    <= '0;
      end else begin
         if (flags_we) flags <= flags_in;
         if (!stall) begin
            wb_valid <= w_enable;
            if (w_enable) begin
               wb_dest <= wrap_sel(dest_reg);
               wb_data <= (w_select == W_SEL_ID) ? w_id : w_alu;
            end
         end
      end
   end

   reg_array #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .SEL_W    (SEL_W)
   ) u_reg_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (commit),
      .w_addr   (wb_dest),
      .w_data   (wb_data),
      .r_addr_0 (sel_0),
      .r_data_0 (arr_val_0),
      .r_addr_1 (sel_1),
      .r_data_1 (arr_val_1)
   );

   // The pending entry is newer than the array, so it wins on a select match
   assign r_val_0 = (wb_valid && wb_dest == sel_0) ? wb_data : arr_val_0;
   assign r_val_1 = (wb_valid && wb_dest == sel_1) ? wb_data : arr_val_1;

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback/register-file block for the single-issue core: the consuming end of the execute stage's write interface (`w_alu`, `w_enable`, `w_select`, `flags`) and the producing end of its operand interface (`r_val_0`, `r_val_1`). Holds the 8×32 general register array and the 4-bit CPSR flag register. A one-entry writeback stage register, with read bypass, sits in front of the array.

## Interface
Parameters:
- `NUM_REGS`, 8: general registers; select width is log2(NUM_REGS).
- `DATA_W`, 32: register width.
- `FLAG_W`, 4: CPSR width, bit order N,C,Z,V (bit 3..0).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `r_sel_0`  in  3  operand-1 register select.
- `r_sel_1`  in  3  operand-2 register select.
- `r_val_0`  out  32  operand-1 value, combinational.
- `r_val_1`  out  32  operand-2 value, combinational.
- `dest_reg`  in  3  write destination.
- `w_enable`  in  1  write request, active high.
- `w_select`  in  1  write-data mux select: 0 = `w_alu`, 1 = `w_id`.
- `w_alu`  in  32  ALU result.
- `w_id`  in  32  decode-supplied data (MOV/MOVT/CLR/SET).
- `flags_we`  in  1  CPSR update strobe.
- `flags_in`  in  4  new N,C,Z,V.
- `flags`  out  4  current CPSR, registered.
- `stall`  in  1  freeze writeback stage.
- `wb_valid`  out  1  writeback stage holds a pending write.
- `wb_dest`  out  3  destination of the pending write; used by hazard logic.

## Operation
- Write capture: at an edge with `rst_n`=1, `stall`=0 and `w_enable`=1, load the stage with `wb_valid`←1, `wb_dest`←`dest_reg`, `wb_data`←(`w_select` ? `w_id` : `w_alu`). With `w_enable`=0 and `stall`=0, `wb_valid`←0.
- Commit: at an edge with `stall`=0 and `wb_valid`=1, the array entry `wb_dest` takes `wb_data`. Commit of the old entry and capture of the new one occur at the same edge.
- Stall: with `stall`=1, the stage holds, nothing commits, and `w_enable` is ignored. The write is dropped, and the producer must hold it. The held entry stays visible through bypass.
- Read: `r_val_k` = (`wb_valid` && `wb_dest`==`r_sel_k`) ? `wb_data` : array[`r_sel_k`]. The two ports are independent, and both may bypass at once. Current-cycle `w_alu`/`w_id` are not forwarded.
- All registers, including R0, are writable. There is no hardwired zero.
- CPSR: `flags`←`flags_in` at any edge with `flags_we`=1. `stall` does not gate it. Otherwise it holds.
- Reset (`rst_n`=0 at an edge): all array entries 0, `flags`=4'b0000, `wb_valid`=0, `wb_dest`=0, `wb_data`=0. A pending write is discarded, including mid-stall. Reset overrides all other inputs in that cycle.

## Timing
- Write presented before edge N: readable via bypass after edge N, and in the array after the next non-stalled edge.
- Back-to-back writes to the same register at edges N and N+1: the edge N value commits at N+1, and the edge N+1 value is bypassed. Reads always return the newest value.
- Flag latency is 1 edge. `flags` is never combinationally derived from `flags_in`.
- Read path: purely combinational from `r_sel_k`, the array, and the stage.
- Out-of-range selects cannot occur at NUM_REGS=8. For other NUM_REGS values, the top index wraps modulo NUM_REGS.

## Structure
- Shared package `scc_pkg`:
  - `DATA_W`, `REG_SEL_W`
  - flag indices `FLAG_N`=3, `FLAG_C`=2, `FLAG_Z`=1, `FLAG_V`=0
  - `W_SEL_ALU`=0, `W_SEL_ID`=1
- Sub-module `reg_array`: NUM_REGS×DATA_W storage, 1 synchronous write port, 2 asynchronous read ports, synchronous active-low clear.
- The top level holds the stage register, the bypass muxes, and the CPSR.

## Test plan
- Reset then read: `rst_n`=0 for 2 edges, then `r_sel_0`=3 and `r_sel_1`=7 → both read 0x00000000, `flags`=0000, `wb_valid`=0.
- ALU write and commit: write R2 with `w_select`=0 and `w_alu`=0xDEADBEEF. After 1 edge, `r_val_0`(sel 2)=0xDEADBEEF via bypass and `wb_valid`=1. After 1 idle edge, the same value comes from the array and `wb_valid`=0.
- Mux and back-to-back: at edge N write R5 with `w_select`=1 and `w_id`=0x00001234. At edge N+1 write R5 with `w_alu`=0x55. After N+1, both ports on sel 5 read 0x55. After an idle edge, the array holds 0x55.
- Stall: write R1=0xA5A5A5A5, then `stall`=1 for 3 edges with `w_enable`=1 and `dest_reg`=1 carrying 0x0 → R1 reads 0xA5A5A5A5 throughout. After release, the commit occurs.
- Flags independent of stall: `stall`=1, `flags_we`=1, `flags_in`=1010 → `flags`=1010 after 1 edge. With `flags_we`=0 and `flags_in`=0101, it holds 1010.
- Reset mid-operation: pending write R4=0x77 with `wb_valid`=1, then `rst_n`=0 for 1 edge → R4 reads 0, `wb_valid`=0, `flags`=0000.
